// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, opcodes and reset defaults for the fetch queue.
// Optional predecode stall is enabled by IFQ_BRANCH_STALL_EN.
package inst_fetch_queue_pkg;

    localparam int Inst_Addr_Width = 17;
    localparam int Inst_Width      = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned RESET_PC_DEF = 0;

    function automatic logic is_ctrl(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Cache, redirect and decode-side signals of the fetch queue.
// master = fetch queue, slave = surrounding cache/backend/decode.
interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = Inst_Addr_Width,
    parameter int INST_W = Inst_Width,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_inst;
    logic              mem_valid;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              deq_valid;
    logic [INST_W-1:0] deq_inst;
    logic [ADDR_W-1:0] deq_pc;
    logic              deq_ready;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output mem_ce, mem_addr, deq_valid, deq_inst, deq_pc, q_count,
        input  mem_inst, mem_valid, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  mem_ce, mem_addr, deq_valid, deq_inst, deq_pc, q_count,
        output mem_inst, mem_valid, redirect_valid, redirect_pc, deq_ready
    );

endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, inst} entries with flush.
// Head reads as zero while the buffer is empty.
module ifq_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Entry storage; a flush drops any write in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC register, cache enable, redirect flush and queue.
// IFQ_BRANCH_STALL_EN adds a predecode stall on control instructions.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          ADDR_W   = Inst_Addr_Width,
    parameter int          INST_W   = Inst_Width,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic clk,
    input  logic rst,
    inst_fetch_queue_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc;
    logic              full;
    logic              empty;
    logic              enq;
    logic              deq;
    logic              stall;
    logic [ENT_W-1:0]  head;
    logic              unused_rpc;

    assign unused_rpc = ^bus.redirect_pc[1:0];

    // Fetch only when there is room, no redirect and no pending stall.
    always_comb begin
        bus.mem_ce = !rst && !full && !bus.redirect_valid && !stall;
        enq        = bus.mem_ce && bus.mem_valid;
        deq        = !empty && bus.deq_ready;
    end

    assign bus.mem_addr  = pc;
    assign bus.deq_valid = !empty;
    assign bus.deq_pc    = head[ENT_W-1:INST_W];
    assign bus.deq_inst  = head[INST_W-1:0];

    // PC: redirect wins, otherwise step by one word per enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (enq) begin
            pc <= pc + ADDR_W'(4);
        end
    end

`ifdef IFQ_BRANCH_STALL_EN
    // Hold fetch after a control instruction until the backend redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall <= 1'b0;
        end else if (bus.redirect_valid) begin
            stall <= 1'b0;
        end else if (enq && is_ctrl(bus.mem_inst[6:0])) begin
            stall <= 1'b1;
        end
    end
`else
    assign stall = 1'b0;
`endif

    ifq_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (enq),
        .pop   (deq),
        .flush (bus.redirect_valid),
        .din   ({pc, bus.mem_inst}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.q_count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue model.
// Build with IFQ_BRANCH_STALL_EN to exercise the predecode stall.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [16:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        deq_ready = 1'b0;
    logic        redir = 1'b0;
    logic [16:0] redir_pc = '0;
    logic        br_en = 1'b0;
    logic [16:0] br_addr = '0;

    int errors = 0;
    int checks = 0;

    ent_t        q[$];
    logic [16:0] m_pc = '0;
    bit          m_stall = 0;
    logic [16:0] prev_pc;

    inst_fetch_queue_if bus ();

    inst_fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cache image: every word is a distinct ALU op unless a branch is planted.
    function automatic logic [31:0] word(input logic [16:0] a,
                                         input logic en,
                                         input logic [16:0] ba);
        if (en && a == ba) return 32'h0000_0063;
        return {a, 8'h00, 7'b0010011};
    endfunction

    assign bus.mem_inst       = word(bus.mem_addr, br_en, br_addr);
    assign bus.mem_valid      = mem_valid;
    assign bus.deq_ready      = deq_ready;
    assign bus.redirect_valid = redir;
    assign bus.redirect_pc    = redir_pc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT against the model, then advance the model across one edge.
    task automatic step();
        bit ce, enq, deq;
        #1;
        ce = (q.size() != DEPTH) && !redir && !m_stall;
        chk("mem_ce", bus.mem_ce, ce);
        chk("mem_addr", bus.mem_addr, m_pc);
        chk("deq_valid", bus.deq_valid, q.size() != 0);
        chk("deq_pc", bus.deq_pc, q.size() != 0 ? q[0].pc : 17'h0);
        chk("deq_inst", bus.deq_inst, q.size() != 0 ? q[0].inst : 32'h0);
        chk("q_count", bus.q_count, q.size());
        enq = ce && mem_valid;
        deq = (q.size() != 0) && deq_ready;
        if (redir) begin
            q.delete();
            m_pc = {redir_pc[16:2], 2'b00};
            m_stall = 0;
        end else begin
            if (deq) void'(q.pop_front());
            if (enq) begin
                ent_t e;
                e.pc = m_pc;
                e.inst = word(m_pc, br_en, br_addr);
                q.push_back(e);
`ifdef IFQ_BRANCH_STALL_EN
                if (e.inst[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011})
                    m_stall = 1;
`endif
                m_pc = m_pc + 17'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic mv, input logic dr,
                          input logic rv, input logic [16:0] rp);
        mem_valid = mv;
        deq_ready = dr;
        redir     = rv;
        redir_pc  = rp;
    endtask

    initial begin
        #1;
        chk("rst_mem_ce", bus.mem_ce, 1'b0);
        chk("rst_q_count", bus.q_count, 3'd0);
        chk("rst_deq_valid", bus.deq_valid, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 17'h0);
        @(negedge clk);
        rst = 1'b0;

        // Free run from reset.
        set_in(1, 1, 0, 0);
        step();
        chk("tp1_first_valid", bus.deq_valid, 1'b1);
        chk("tp1_first_inst", bus.deq_inst, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            chk("tp1_pc_seq", bus.deq_pc, 17'(i * 4));
            step();
        end

        // Fill to full and release one entry.
        set_in(0, 0, 1, 17'h0);
        step();
        set_in(1, 0, 0, 0);
        repeat (4) step();
        chk("full_count", bus.q_count, 3'd4);
        chk("full_ce", bus.mem_ce, 1'b0);
        chk("full_pc", bus.mem_addr, 17'h10);
        step();
        chk("full_pc_held", bus.mem_addr, 17'h10);
        deq_ready = 1;
        step();
        deq_ready = 0;
        chk("pulse_count", bus.q_count, 3'd3);
        chk("pulse_ce", bus.mem_ce, 1'b1);
        step();
        chk("refill_count", bus.q_count, 3'd4);

        // Redirect with three entries queued.
        set_in(0, 0, 1, 17'h0);
        step();
        set_in(1, 0, 0, 0);
        repeat (3) step();
        chk("redir_pre_count", bus.q_count, 3'd3);
        set_in(1, 1, 1, 17'h43);
        step();
        chk("redir_count", bus.q_count, 3'd0);
        chk("redir_addr", bus.mem_addr, 17'h40);
        set_in(1, 0, 0, 0);
        step();
        chk("redir_deq_pc", bus.deq_pc, 17'h40);

        // Steady enqueue and dequeue at occupancy two.
        set_in(0, 0, 1, 17'h100);
        step();
        set_in(1, 0, 0, 0);
        repeat (2) step();
        deq_ready = 1;
        prev_pc = bus.deq_pc;
        chk("steady_first_pc", prev_pc, 17'h100);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("steady_count", bus.q_count, 3'd2);
            chk("steady_pc_inc", bus.deq_pc, prev_pc + 17'd4);
            prev_pc = bus.deq_pc;
        end

        // Cache not valid for three cycles.
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mv0_pc_held", bus.mem_addr, 17'h130);
        end
        set_in(1, 0, 0, 0);
        step();
        chk("mv0_resume", bus.mem_addr, 17'h134);

        // Control instruction at 0x8.
        set_in(0, 0, 1, 17'h0);
        step();
        br_en = 1;
        br_addr = 17'h8;
        set_in(1, 1, 0, 0);
        repeat (4) step();
`ifdef IFQ_BRANCH_STALL_EN
        chk("br_stall_ce", bus.mem_ce, 1'b0);
        chk("br_stall_pc", bus.mem_addr, 17'hC);
        set_in(1, 1, 1, 17'h20);
        step();
        set_in(1, 1, 0, 0);
        chk("br_resume_ce", bus.mem_ce, 1'b1);
        chk("br_resume_pc", bus.mem_addr, 17'h20);
        step();
`else
        chk("br_no_stall_pc", bus.mem_addr, 17'h10);
`endif
        br_en = 0;

        // PC wrap at the top of the address space.
        set_in(0, 0, 1, 17'h1FFFF);
        step();
        chk("wrap_addr", bus.mem_addr, 17'h1FFFC);
        set_in(1, 0, 0, 0);
        step();
        chk("wrap_zero", bus.mem_addr, 17'h0);
        chk("wrap_deq_pc", bus.deq_pc, 17'h1FFFC);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                set_in(1, 0, 0, 0);
                #2;
                rst = 1'b1;
                #1;
                chk("mid_rst_ce", bus.mem_ce, 1'b0);
                chk("mid_rst_count", bus.q_count, 3'd0);
                chk("mid_rst_valid", bus.deq_valid, 1'b0);
                chk("mid_rst_addr", bus.mem_addr, 17'h0);
                q.delete();
                m_pc = '0;
                m_stall = 0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
            set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 19) == 0), 17'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
